i2c_tx_fifo: RTL
================

// Module: i2c_tx_fifo
// PURPOSE
//  Synchronous transmit FIFO between the MCU data register and the I2C master core.
//  Buffers bytes written by the MCU and presents the head byte to the data path.
//  The master FSM pops bytes with its read-enable; full/empty flags feed the FSM.
//  Packed flags drive the status byte returned to the MCU.
// PARAMETERS
//  DATA_SIZE   8  width of one FIFO word (bits)
//  DEPTH_LOG2  4  log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 16)
//  AF_LEVEL    14 almost_full asserted when count >= AF_LEVEL
//  AE_LEVEL    2  almost_empty asserted when count <= AE_LEVEL
// PORTS
//  i2c_core_clk_i  in   1               single clock; all state on rising edge
//  reset_ni        in   1               async active-low reset
//  clear_i         in   1               sync flush: pointers, count, sticky flags -> 0
//  data_i          in   DATA_SIZE       write data from MCU
//  w_fifo_en_i     in   1               write request, one word per cycle
//  r_fifo_en_i     in   1               read (pop) request from master FSM
//  data_o          out  DATA_SIZE       head word (first-word fall-through)
//  full_o          out  1               count == DEPTH
//  empty_o         out  1               count == 0
//  almost_full_o   out  1               count >= AF_LEVEL
//  almost_empty_o  out  1               count <= AE_LEVEL
//  overflow_o      out  1               sticky: write dropped while full
//  underflow_o     out  1               sticky: read while empty
//  count_o         out  DEPTH_LOG2+1    words stored, 0..DEPTH
//  status_o        out  8               {2'b0,underflow,overflow,a_empty,a_full,empty,full}
// BEHAVIOUR
//  - Reset (async, reset_ni=0): wr_ptr=rd_ptr=0, count=0, overflow=underflow=0;
//    so empty_o=1, almost_empty_o=1, full_o=almost_full_o=0, data_o=0, status_o=8'h0A.
//    Memory contents not reset.
//  - Pointers are DEPTH_LOG2+1 bits. MSB is the wrap bit.
//    full  = addr bits equal and wrap bits differ; empty = pointers identical.
//  - rd_acc = r_fifo_en_i & ~empty.
//  - wr_acc = w_fifo_en_i & (~full | rd_acc). A write into a full FIFO is accepted
//    only when a pop happens in the same cycle.
//  - Write: mem[wr_ptr] <= data_i; wr_ptr+1 wraps modulo 2*DEPTH. Pop: rd_ptr+1, same wrap.
//  - count_o: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
//    All flags are derived combinationally from the registered pointers and count.
//  - data_o = mem[rd_ptr] while ~empty, else 0. Zero latency: the head word is visible
//    in the cycle after its write when the FIFO was empty.
//  - Empty + write + read in the same cycle: the write is accepted, the read is ignored,
//    and underflow is set.
//  - overflow <= 1 when w_fifo_en_i & ~wr_acc. underflow <= 1 when r_fifo_en_i & empty.
//    Both hold until clear_i or reset.
//  - clear_i has priority over same-cycle read/write; those requests are discarded
//    and do not set the sticky flags.
//  - No FSM beyond the pointer/count registers. All outputs glitch-free w.r.t. the clock.
// STRUCTURE
//  - i2c_pkg: STATUS_FULL=0, STATUS_EMPTY=1, STATUS_AFULL=2, STATUS_AEMPTY=3,
//    STATUS_OVF=4, STATUS_UDF=5 bit-index constants, shared with MCU register decode.
//  - Sub-module i2c_fifo_mem: DEPTH x DATA_SIZE register array,
//    one sync write port and one async read port.
//  - Top holds the pointers, count, flag logic and status packing.
// TESTING
//  1. Reset -> empty_o=1, count_o=0, status_o=8'h0A; release reset, idle 5 cycles -> unchanged.
//  2. Write 8'hA5,8'h3C,8'hFF, then pop 3 -> data_o shows A5, 3C, FF in order;
//     empty_o=1 after the third pop.
//  3. Write 16 words 0..15 -> full_o=1, count_o=16, almost_full_o from count 14.
//     17th write -> dropped, overflow_o=1, data_o still 0.
//  4. Full FIFO with simultaneous write 8'h77 and pop -> count stays 16, overflow_o=0;
//     drain -> 1..15 then 77 (word 0 was popped in that cycle).
//  5. Empty FIFO with pop -> underflow_o=1, count_o=0.
//     Empty with write 8'h11 + pop -> count_o=1, data_o=11.
//  6. 5 words stored, clear_i + write in the same cycle -> count_o=0, sticky flags 0;
//     assert reset_ni mid-burst -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
//   Definitions shared between the I2C transmit FIFO and the MCU register
//   decode: the bit positions of the FIFO status byte and a helper that packs
//   the individual flags into that byte.
// ---------------------------------------------------------------------------
package i2c_pkg;

  // Bit positions inside the status byte returned to the MCU.
  localparam int STATUS_FULL   = 0;
  localparam int STATUS_EMPTY  = 1;
  localparam int STATUS_AFULL  = 2;
  localparam int STATUS_AEMPTY = 3;
  localparam int STATUS_OVF    = 4;
  localparam int STATUS_UDF    = 5;

  localparam int STATUS_W = 8;

  // Places each flag at its bit position. Bits 7:6 are always zero.
  function automatic logic [STATUS_W-1:0] pack_status(
    input logic full,
    input logic empty,
    input logic afull,
    input logic aempty,
    input logic ovf,
    input logic udf
  );
    logic [STATUS_W-1:0] s;
    s                = '0;
    s[STATUS_FULL]   = full;
    s[STATUS_EMPTY]  = empty;
    s[STATUS_AFULL]  = afull;
    s[STATUS_AEMPTY] = aempty;
    s[STATUS_OVF]    = ovf;
    s[STATUS_UDF]    = udf;
    return s;
  endfunction

endpackage : i2c_pkg

// File: rtl/i2c_fifo_mem.sv
// ---------------------------------------------------------------------------
// i2c_fifo_mem
//   Storage array of the transmit FIFO: 2**ADDR_W words of DATA_SIZE bits,
//   one synchronous write port and one asynchronous (combinational) read port
//   so the head word is visible without a read-latency cycle.
// Ports
//   i_clk      clock, write on rising edge
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address
//   o_rd_data  word at i_rd_addr
// ---------------------------------------------------------------------------
module i2c_fifo_mem #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_W    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_wr_en,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [DATA_SIZE-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  output logic [DATA_SIZE-1:0] o_rd_data
);

  logic [DATA_SIZE-1:0] r_mem [2**ADDR_W];

  // NOTE: the array has no reset on purpose; stale words are never visible
  // because the read side masks the output while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule : i2c_fifo_mem

// File: rtl/i2c_tx_fifo.sv
// ---------------------------------------------------------------------------
// i2c_tx_fifo
//   Transmit FIFO between the MCU data register and the I2C master core.
//   First-word fall-through: data_o always shows the head word (0 when empty).
//   The master FSM pops with r_fifo_en_i; flags feed the FSM and the MCU
//   status byte.
// Ports
//   i2c_core_clk_i  clock                      reset_ni       async reset, low
//   clear_i         sync flush                 data_i         write data
//   w_fifo_en_i     write request              r_fifo_en_i    pop request
//   data_o          head word                  count_o        words stored
//   full_o/empty_o  occupancy limits           almost_full_o/almost_empty_o
//   overflow_o      sticky dropped write       underflow_o    sticky empty read
//   status_o        {2'b0,udf,ovf,a_empty,a_full,empty,full}
// ---------------------------------------------------------------------------
module i2c_tx_fifo
  import i2c_pkg::*;
#(
  parameter int DATA_SIZE  = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  i2c_core_clk_i,
  input  logic                  reset_ni,
  input  logic                  clear_i,
  input  logic [DATA_SIZE-1:0]  data_i,
  input  logic                  w_fifo_en_i,
  input  logic                  r_fifo_en_i,
  output logic [DATA_SIZE-1:0]  data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic [STATUS_W-1:0]   status_o
);

  localparam logic [DEPTH_LOG2:0] AF_CNT = AF_LEVEL[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] AE_CNT = AE_LEVEL[DEPTH_LOG2:0];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the address bits coincide.
  logic [DEPTH_LOG2:0]   r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_mem_we;
  logic [DATA_SIZE-1:0]  w_rd_data;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                   (r_wr_ptr[DEPTH_LOG2]     != r_rd_ptr[DEPTH_LOG2]);

  // A write into a full FIFO is still accepted when the same cycle pops,
  // because the popped slot is the one being overwritten.
  assign w_rd_acc = r_fifo_en_i & ~w_empty;
  assign w_wr_acc = w_fifo_en_i & (~w_full | w_rd_acc);

  // A flush discards same-cycle requests, including the array write.
  assign w_mem_we = w_wr_acc & ~clear_i;

  i2c_fifo_mem #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_W    (DEPTH_LOG2)
  ) u_mem (
    .i_clk     (i2c_core_clk_i),
    .i_wr_en   (w_mem_we),
    .i_wr_addr (r_wr_ptr[DEPTH_LOG2-1:0]),
    .i_wr_data (data_i),
    .i_rd_addr (r_rd_ptr[DEPTH_LOG2-1:0]),
    .o_rd_data (w_rd_data)
  );

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_fifo_en_i & ~w_wr_acc) r_overflow  <= 1'b1;
      if (r_fifo_en_i & w_empty)   r_underflow <= 1'b1;
    end
  end

  // Outputs are functions of registers only, so they cannot glitch on inputs.
  assign data_o         = w_empty ? '0 : w_rd_data;
  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign almost_full_o  = (r_count >= AF_CNT);
  assign almost_empty_o = (r_count <= AE_CNT);
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;
  assign count_o        = r_count;

  // NOTE: the status byte is given a default before packing so that no path
  // through this block can leave it unassigned and infer a latch.
  always_comb begin
    status_o = '0;
    status_o = pack_status(w_full, w_empty, almost_full_o, almost_empty_o,
                           r_overflow, r_underflow);
  end

endmodule : i2c_tx_fifo
